// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  cpu_pkg
//  Shared CPU datapath constants and the call-stack entry layout.
//  Revision: 1.0
// ============================================================================
package cpu_pkg;

  localparam int STACK_W = 11;
  localparam int RA3_HI  = 10;
  localparam int RA3_LO  = 8;
  localparam int DATA_HI = 7;
  localparam int DATA_LO = 0;

  typedef struct packed {
    logic [RA3_HI-RA3_LO:0]   ra3;
    logic [DATA_HI-DATA_LO:0] data;
  } stack_entry_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/call_stack_if.sv
`default_nettype none
// ============================================================================
//  call_stack_if
//  Request/response bundle of the call stack. With CALL_STACK_STICKY_ERR_EN
//  defined the bundle also carries err_clr.
//  Revision: 1.0
// ============================================================================
interface call_stack_if
  import cpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = STACK_W
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH-1:0] read_data_stack;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;
`ifdef CALL_STACK_STICKY_ERR_EN
  logic             err_clr;
`endif

  modport master (
`ifdef CALL_STACK_STICKY_ERR_EN
    output err_clr,
`endif
    output push, pop, push_data,
    input  read_data_stack, count, full, empty, overflow, underflow
  );

  modport slave (
`ifdef CALL_STACK_STICKY_ERR_EN
    input  err_clr,
`endif
    input  push, pop, push_data,
    output read_data_stack, count, full, empty, overflow, underflow
  );

endinterface : call_stack_if
`default_nettype wire

// File: rtl/call_stack.sv
`default_nettype none
// ============================================================================
//  call_stack
//  Return-address/data stack with zero-latency top-of-stack read.
//  Optional macro CALL_STACK_STICKY_ERR_EN: sticky overflow/underflow + err_clr.
//  Revision: 1.0
// ============================================================================
module call_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = STACK_W,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  call_stack_if.slave bus
);

  localparam logic [PTR_W:0] c_DEPTH_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] c_ONE_CNT   = (PTR_W+1)'(1);

  stack_entry_t     mem_q [DEPTH];
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             unf_q;
  logic             unf_d;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_en;
  logic             w_ovf_evt;
  logic             w_unf_evt;
  logic [PTR_W-1:0] w_top_idx;
  logic [PTR_W-1:0] w_wr_idx;
  logic [WIDTH-1:0] w_top_data;
  stack_entry_t     w_push_entry;

  assign w_full  = (count_q == c_DEPTH_CNT);
  assign w_empty = (count_q == '0);

  // When full the low pointer bits wrap to 0, so subtracting one still lands on DEPTH-1.
  assign w_top_idx = count_q[PTR_W-1:0] - PTR_W'(1);

  // Push+pop on a non-empty stack replaces the top; otherwise a push appends.
  assign w_wr_en      = rst_n && bus.push && (!w_full || bus.pop);
  assign w_wr_idx     = (bus.pop && !w_empty) ? w_top_idx : count_q[PTR_W-1:0];
  assign w_push_entry = bus.push_data;

  assign w_ovf_evt = bus.push && !bus.pop && w_full;
  assign w_unf_evt = bus.pop && !bus.push && w_empty;

  always_comb begin
    count_d = count_q;
    unique case ({bus.push, bus.pop})
      2'b10: if (!w_full)  count_d = count_q + c_ONE_CNT;
      2'b01: if (!w_empty) count_d = count_q - c_ONE_CNT;
      2'b11: if (w_empty)  count_d = c_ONE_CNT;
      default: count_d = count_q;
    endcase
  end

`ifdef CALL_STACK_STICKY_ERR_EN
  // A fresh error in the same cycle as err_clr keeps the flag set.
  always_comb begin
    ovf_d = w_ovf_evt || (ovf_q && !bus.err_clr);
    unf_d = w_unf_evt || (unf_q && !bus.err_clr);
  end
`else
  always_comb begin
    ovf_d = w_ovf_evt;
    unf_d = w_unf_evt;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is not reset; every read is masked by the empty flag.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[w_wr_idx] <= w_push_entry;
    end
  end

  assign w_top_data = w_empty ? '0 : mem_q[w_top_idx];

  assign bus.read_data_stack = w_top_data;
  assign bus.count           = count_q;
  assign bus.full            = w_full;
  assign bus.empty           = w_empty;
  assign bus.overflow        = ovf_q;
  assign bus.underflow       = unf_q;

endmodule : call_stack
`default_nettype wire

// File: tb/tb_call_stack.sv
`default_nettype none
// ============================================================================
//  tb_call_stack
//  Self-checking bench for call_stack against a queue-based stack model.
//  Revision: 1.0
// ============================================================================
module tb_call_stack;
  import cpu_pkg::*;

  localparam int DEPTH = 8;
  localparam int PTR_W = $clog2(DEPTH);
`ifdef CALL_STACK_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef logic [PTR_W+15:0] vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  call_stack_if #(.DEPTH(DEPTH)) bus ();

  call_stack #(.DEPTH(DEPTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  logic [10:0] model_q[$];
  bit          m_ovf;
  bit          m_unf;

  function automatic vec_t exp_vec();
    logic [10:0] top;
    top = (model_q.size() == 0) ? 11'h000 : model_q[model_q.size()-1];
    return {(PTR_W+1)'(model_q.size()), model_q.size() == DEPTH, model_q.size() == 0,
            m_ovf, m_unf, top};
  endfunction

  function automatic vec_t obs();
    return {bus.count, bus.full, bus.empty, bus.overflow, bus.underflow, bus.read_data_stack};
  endfunction

  task automatic model_apply(input bit p, input bit q, input logic [10:0] d, input bit clr);
    bit oe;
    bit ue;
    oe = 1'b0;
    ue = 1'b0;
    if (!rst_n) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    if (p && q) begin
      if (model_q.size() == 0) model_q.push_back(d);
      else model_q[model_q.size()-1] = d;
    end else if (p) begin
      if (model_q.size() == DEPTH) oe = 1'b1;
      else model_q.push_back(d);
    end else if (q) begin
      if (model_q.size() == 0) ue = 1'b1;
      else void'(model_q.pop_back());
    end
    m_ovf = oe || (STICKY && m_ovf && !clr);
    m_unf = ue || (STICKY && m_unf && !clr);
  endtask

  task automatic step(input bit p, input bit q, input logic [10:0] d, input bit clr);
    bus.push      = p;
    bus.pop       = q;
    bus.push_data = d;
`ifdef CALL_STACK_STICKY_ERR_EN
    bus.err_clr   = clr;
`endif
    @(posedge clk);
    model_apply(p, q, d, clr);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
`ifdef CALL_STACK_STICKY_ERR_EN
    bus.err_clr = 1'b0;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 11'h000, 1'b0);
    step(1'b0, 1'b0, 11'h000, 1'b0);
    rst_n = 1'b1;
  endtask

  function automatic logic [10:0] fill_val(input int k);
    logic [2:0] ra;
    ra = (k > 7) ? 3'd7 : 3'(k);
    return {ra, 8'(k)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b1, 1'b0, 11'h123, 1'b0);
    step(1'b1, 1'b1, 11'h456, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 11'h000, 1'b0);
    n_run++;
    if (obs() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_vec: got %h want %h", obs(), exp_vec());
    end
    n_run++;
    if ({bus.count, bus.empty, bus.full, bus.read_data_stack, bus.overflow, bus.underflow}
        !== {4'd0, 1'b1, 1'b0, 11'h000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: count=%0d empty=%b full=%b top=%h ovf=%b unf=%b want 0 1 0 000 0 0",
               bus.count, bus.empty, bus.full, bus.read_data_stack, bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int k = 1; k <= DEPTH; k++) begin
      step(1'b1, 1'b0, fill_val(k), 1'b0);
      n_run++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL fill_%0d: got %h want %h", k, obs(), exp_vec());
      end
    end
    n_run++;
    if ({bus.full, bus.count, bus.read_data_stack} !== {1'b1, 4'd8, 11'h708}) begin
      n_fail++;
      $display("FAIL fill_top: full=%b count=%0d top=%h want 1 8 708",
               bus.full, bus.count, bus.read_data_stack);
    end
    for (int k = DEPTH; k >= 1; k--) begin
      n_run++;
      if (bus.read_data_stack !== fill_val(k)) begin
        n_fail++;
        $display("FAIL drain_top_%0d: got %h want %h", k, bus.read_data_stack, fill_val(k));
      end
      step(1'b0, 1'b1, 11'h000, 1'b0);
    end
    n_run++;
    if (obs() !== exp_vec() || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_end: got %h want %h", obs(), exp_vec());
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 1; k <= DEPTH; k++) step(1'b1, 1'b0, fill_val(k), 1'b0);
    step(1'b1, 1'b0, 11'h7FF, 1'b0);
    n_run++;
    if ({bus.overflow, bus.count, bus.read_data_stack} !== {1'b1, 4'd8, 11'h708}) begin
      n_fail++;
      $display("FAIL overflow_hit: ovf=%b count=%0d top=%h want 1 8 708",
               bus.overflow, bus.count, bus.read_data_stack);
    end
    step(1'b0, 1'b0, 11'h000, 1'b0);
    n_run++;
    if (obs() !== exp_vec()) begin
      n_fail++;
      $display("FAIL overflow_after: got %h want %h", obs(), exp_vec());
    end
    step(1'b0, 1'b1, 11'h000, 1'b0);
    n_run++;
    if (bus.read_data_stack !== 11'h707 || obs() !== exp_vec()) begin
      n_fail++;
      $display("FAIL overflow_pop: got %h want %h", obs(), exp_vec());
    end
  endtask

  task automatic test_underflow();
    do_reset();
    step(1'b0, 1'b1, 11'h000, 1'b0);
    n_run++;
    if ({bus.underflow, bus.count, bus.read_data_stack} !== {1'b1, 4'd0, 11'h000}) begin
      n_fail++;
      $display("FAIL underflow_hit: unf=%b count=%0d top=%h want 1 0 000",
               bus.underflow, bus.count, bus.read_data_stack);
    end
    step(1'b0, 1'b0, 11'h000, 1'b0);
    n_run++;
    if (obs() !== exp_vec()) begin
      n_fail++;
      $display("FAIL underflow_after: got %h want %h", obs(), exp_vec());
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(1'b1, 1'b0, 11'h111, 1'b0);
    step(1'b1, 1'b0, 11'h222, 1'b0);
    step(1'b1, 1'b0, 11'h333, 1'b0);
    step(1'b1, 1'b1, 11'h555, 1'b0);
    n_run++;
    if ({bus.count, bus.read_data_stack, bus.overflow, bus.underflow}
        !== {4'd3, 11'h555, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL swap_top: count=%0d top=%h ovf=%b unf=%b want 3 555 0 0",
               bus.count, bus.read_data_stack, bus.overflow, bus.underflow);
    end
    repeat (3) step(1'b0, 1'b1, 11'h000, 1'b0);
    step(1'b1, 1'b1, 11'h0AA, 1'b0);
    n_run++;
    if ({bus.count, bus.read_data_stack, bus.underflow} !== {4'd1, 11'h0AA, 1'b0}) begin
      n_fail++;
      $display("FAIL swap_empty: count=%0d top=%h unf=%b want 1 0aa 0",
               bus.count, bus.read_data_stack, bus.underflow);
    end
    for (int k = 2; k <= DEPTH; k++) step(1'b1, 1'b0, fill_val(k), 1'b0);
    step(1'b1, 1'b1, 11'h3C3, 1'b0);
    n_run++;
    if (obs() !== exp_vec()) begin
      n_fail++;
      $display("FAIL swap_full: got %h want %h", obs(), exp_vec());
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    for (int k = 1; k <= 5; k++) step(1'b1, 1'b0, fill_val(k), 1'b0);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 11'h6E6, 1'b0);
    rst_n = 1'b1;
    n_run++;
    if ({bus.count, bus.empty, bus.read_data_stack} !== {4'd0, 1'b1, 11'h000}) begin
      n_fail++;
      $display("FAIL reset_mid: count=%0d empty=%b top=%h want 0 1 000",
               bus.count, bus.empty, bus.read_data_stack);
    end
  endtask

`ifdef CALL_STACK_STICKY_ERR_EN
  task automatic test_sticky();
    do_reset();
    for (int k = 1; k <= DEPTH; k++) step(1'b1, 1'b0, fill_val(k), 1'b0);
    step(1'b1, 1'b0, 11'h7FF, 1'b0);
    repeat (3) step(1'b0, 1'b0, 11'h000, 1'b0);
    n_run++;
    if (bus.overflow !== 1'b1 || obs() !== exp_vec()) begin
      n_fail++;
      $display("FAIL sticky_hold: ovf=%b want 1", bus.overflow);
    end
    step(1'b1, 1'b0, 11'h7FF, 1'b1);
    n_run++;
    if (bus.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_new_wins: ovf=%b want 1", bus.overflow);
    end
    step(1'b0, 1'b0, 11'h000, 1'b1);
    n_run++;
    if (bus.overflow !== 1'b0 || obs() !== exp_vec()) begin
      n_fail++;
      $display("FAIL sticky_clear: ovf=%b want 0", bus.overflow);
    end
  endtask
`endif

  task automatic test_random();
    bit p;
    bit q;
    bit c;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      p = ($urandom_range(0, 99) < 50);
      q = ($urandom_range(0, 99) < 40);
      c = ($urandom_range(0, 99) < 10);
      step(p, q, 11'($urandom), c);
      n_run++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_%0d: push=%b pop=%b got %h want %h", i, p, q, obs(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.push_data = '0;
`ifdef CALL_STACK_STICKY_ERR_EN
    bus.err_clr   = 1'b0;
`endif
    m_ovf = 1'b0;
    m_unf = 1'b0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_reset_mid_op();
`ifdef CALL_STACK_STICKY_ERR_EN
    test_sticky();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule : tb_call_stack
`default_nettype wire
